ram_master: RTL and testbench



---
 rtl/ram_master.sv | 153 +++++++++++++++
 tb/tb_ram_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_master.sv
// ram_master: request-side controller for a single-port wr_rd RAM.
// Takes one write/read command at a time over valid/ready and produces
// one-cycle wr_rd strobes with registered address and data. For reads it
// captures dout after RD_LAT cycles and returns it over a valid/ready
// response port that honours backpressure.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// WR    | write strobe (2'b10) on the RAM pins for this one cycle
// RD    | read strobe (2'b01) on the RAM pins for this one cycle
// WAIT  | counting down the read latency, dout sampled when cnt == 0
// RSP   | rsp_valid held with stable data until rsp_ready
module ram_master #(
  parameter int DIW    = 16,
  parameter int DOW    = 16,
  parameter int ADW    = 4,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_wr,
  input  logic [ADW-1:0] cmd_addr,
  input  logic [DIW-1:0] cmd_wdata,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DOW-1:0] rsp_data,
  output logic           busy,
  output logic [1:0]     ram_wr_rd,
  output logic [DIW-1:0] ram_din,
  output logic [ADW-1:0] ram_addr,
  input  logic [DOW-1:0] ram_dout
);

  // Four bits covers the full legal latency range 1..15.
  localparam int CW = 4;
  localparam logic [CW-1:0] LAT_LOAD = CW'(RD_LAT - 1);

  localparam logic [1:0] WR_RD_IDLE  = 2'b00;
  localparam logic [1:0] WR_RD_WRITE = 2'b10;
  localparam logic [1:0] WR_RD_READ  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_WAIT,
    S_RSP
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     ram_wr_rd_q;
  logic [DIW-1:0] ram_din_q;
  logic [ADW-1:0] ram_addr_q;
  logic           rsp_valid_q;
  logic [DOW-1:0] rsp_data_q;
  logic           busy_q;
  logic           cmd_ready_q;

  // The acceptance condition only needs cmd_valid: cmd_ready_q is high
  // exactly when the FSM sits in IDLE.
  logic cmd_fire;
  logic rsp_fire;
  assign cmd_fire = cmd_valid & cmd_ready_q;
  assign rsp_fire = rsp_valid_q & rsp_ready;

  // Sequencer: state, latency counter and every output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ram_wr_rd_q <= WR_RD_IDLE;
      ram_din_q   <= '0;
      ram_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            ram_addr_q  <= cmd_addr;
            ram_din_q   <= cmd_wdata;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cmd_wr) begin
              ram_wr_rd_q <= WR_RD_WRITE;
              state_q     <= S_WR;
            end else begin
              ram_wr_rd_q <= WR_RD_READ;
              state_q     <= S_RD;
            end
          end
        end

        S_WR: begin
          // Writes produce no response; back to IDLE after the strobe.
          ram_wr_rd_q <= WR_RD_IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end

        S_RD: begin
          // Counter reaches zero in the cycle where dout becomes valid.
          ram_wr_rd_q <= WR_RD_IDLE;
          cnt_q       <= LAT_LOAD;
          state_q     <= S_WAIT;
        end

        S_WAIT: begin
          if (cnt_q == '0) begin
            rsp_data_q  <= ram_dout;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RSP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_RSP: begin
          if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          ram_wr_rd_q <= WR_RD_IDLE;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign ram_wr_rd = ram_wr_rd_q;
  assign ram_din   = ram_din_q;
  assign ram_addr  = ram_addr_q;

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master: one instance with RD_LAT = 1 and one with
// RD_LAT = 3, each attached to a small behavioural RAM whose dout is only
// meaningful in the exact cycle the read latency promises.
module tb_ram_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // RD_LAT = 1 instance
  logic        cmd_valid = 1'b0, cmd_wr = 1'b0, rsp_ready = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, busy;
  logic [15:0] rsp_data, ram_din, ram_dout;
  logic [3:0]  ram_addr;
  logic [1:0]  ram_wr_rd;

  // RD_LAT = 3 instance
  logic        c3_valid = 1'b0, c3_wr = 1'b0, c3_rsp_ready = 1'b0;
  logic [3:0]  c3_addr = '0;
  logic [15:0] c3_wdata = '0;
  logic        c3_ready, c3_rsp_valid, c3_busy;
  logic [15:0] c3_rsp_data, c3_din, c3_dout;
  logic [3:0]  c3_ram_addr;
  logic [1:0]  c3_wr_rd;

  ram_master #(.DIW(16), .DOW(16), .ADW(4), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .ram_wr_rd(ram_wr_rd), .ram_din(ram_din),
    .ram_addr(ram_addr), .ram_dout(ram_dout)
  );

  ram_master #(.DIW(16), .DOW(16), .ADW(4), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_wr(c3_wr),
    .cmd_addr(c3_addr), .cmd_wdata(c3_wdata),
    .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready), .rsp_data(c3_rsp_data),
    .busy(c3_busy), .ram_wr_rd(c3_wr_rd), .ram_din(c3_din),
    .ram_addr(c3_ram_addr), .ram_dout(c3_dout)
  );

  // RAM models: dout reads 16'hDEAD except in strobe cycle + latency.
  logic [15:0] mem1 [16];
  logic        p1_v = 1'b0;
  logic [15:0] p1_d = '0;
  always @(posedge clk) begin
    if (ram_wr_rd == 2'b10) mem1[ram_addr] <= ram_din;
    p1_v <= (ram_wr_rd == 2'b01);
    p1_d <= mem1[ram_addr];
  end
  assign ram_dout = p1_v ? p1_d : 16'hDEAD;

  logic [15:0] mem3 [16];
  logic [2:0]  p3_v = '0;
  logic [15:0] p3_d0 = '0, p3_d1 = '0, p3_d2 = '0;
  always @(posedge clk) begin
    if (c3_wr_rd == 2'b10) mem3[c3_ram_addr] <= c3_din;
    p3_v  <= {p3_v[1:0], (c3_wr_rd == 2'b01)};
    p3_d0 <= mem3[c3_ram_addr];
    p3_d1 <= p3_d0;
    p3_d2 <= p3_d1;
  end
  assign c3_dout = p3_v[2] ? p3_d2 : 16'hDEAD;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (ram_wr_rd !== 2'b00) begin n_err++; $display("FAIL rst_wr_rd: got %b want 00", ram_wr_rd); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (ram_addr !== 4'd0) begin n_err++; $display("FAIL rst_addr: got %0d want 0", ram_addr); end
    n_cmp++; if (ram_din !== 16'd0) begin n_err++; $display("FAIL rst_din: got %0h want 0", ram_din); end
    n_cmp++; if (rsp_data !== 16'd0) begin n_err++; $display("FAIL rst_rsp_data: got %0h want 0", rsp_data); end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (c3_ready !== 1'b1) begin n_err++; $display("FAIL rst_c3_ready: got %b want 1", c3_ready); end
  endtask

  task automatic test_write();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd2; cmd_wdata = 16'd10;
    step();
    cmd_valid = 1'b0;
    n_cmp++; if (ram_wr_rd !== 2'b10) begin n_err++; $display("FAIL wr_strobe: got %b want 10", ram_wr_rd); end
    n_cmp++; if (ram_addr !== 4'd2) begin n_err++; $display("FAIL wr_addr: got %0d want 2", ram_addr); end
    n_cmp++; if (ram_din !== 16'd10) begin n_err++; $display("FAIL wr_din: got %0d want 10", ram_din); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_low: got %b want 0", cmd_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b want 1", busy); end
    step();
    n_cmp++; if (ram_wr_rd !== 2'b00) begin n_err++; $display("FAIL wr_strobe_end: got %b want 00", ram_wr_rd); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_back: got %b want 1", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_no_rsp: got %b want 0", rsp_valid); end
    n_cmp++; if (ram_addr !== 4'd2) begin n_err++; $display("FAIL wr_addr_hold: got %0d want 2", ram_addr); end
  endtask

  task automatic test_read_lat1();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd3; cmd_wdata = 16'd20;
    step();
    cmd_valid = 1'b0;
    n_cmp++; if (ram_din !== 16'd20) begin n_err++; $display("FAIL wr3_din: got %0d want 20", ram_din); end
    step();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd2; cmd_wdata = 16'h5555;
    step();
    cmd_valid = 1'b0;
    n_cmp++; if (ram_wr_rd !== 2'b01) begin n_err++; $display("FAIL rd_strobe: got %b want 01", ram_wr_rd); end
    n_cmp++; if (ram_addr !== 4'd2) begin n_err++; $display("FAIL rd_addr: got %0d want 2", ram_addr); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_early_a1: got %b want 0", rsp_valid); end
    step();
    n_cmp++; if (ram_wr_rd !== 2'b00) begin n_err++; $display("FAIL rd_strobe_end: got %b want 00", ram_wr_rd); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_early_a2: got %b want 0", rsp_valid); end
    step();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rd_valid_a3: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 16'd10) begin n_err++; $display("FAIL rd_data: got %0d want 10", rsp_data); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_one_cycle: got %b want 0", rsp_valid); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready_back: got %b want 1", cmd_ready); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd3;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    // A write sits on the port during the hold; it must wait for IDLE.
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd7; cmd_wdata = 16'h0077;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, rsp_valid); end
      n_cmp++; if (rsp_data !== 16'd20) begin n_err++; $display("FAIL bp_data[%0d]: got %0d want 20", i, rsp_data); end
      n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", i, cmd_ready); end
      n_cmp++; if (ram_wr_rd !== 2'b00) begin n_err++; $display("FAIL bp_no_strobe[%0d]: got %b want 00", i, ram_wr_rd); end
      step();
    end
    rsp_ready = 1'b1;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_rel: got %b want 1", rsp_valid); end
    step();
    rsp_ready = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_released: got %b want 0", rsp_valid); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    n_cmp++; if (ram_wr_rd !== 2'b10) begin n_err++; $display("FAIL bp_held_cmd: got %b want 10", ram_wr_rd); end
    n_cmp++; if (ram_addr !== 4'd7) begin n_err++; $display("FAIL bp_held_addr: got %0d want 7", ram_addr); end
    n_cmp++; if (ram_din !== 16'h0077) begin n_err++; $display("FAIL bp_held_din: got %0h want 77", ram_din); end
    step();
  endtask

  task automatic test_back_to_back();
    logic        wr_seq [4];
    logic [15:0] wd_seq [4];
    logic [15:0] exp_rsp [2];
    int idx, wr_cnt, rd_cnt, rsp_cnt;
    logic prev_nz;
    wr_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
    wd_seq = '{16'h1111, 16'hAAAA, 16'h2222, 16'hBBBB};
    exp_rsp = '{16'h1111, 16'h2222};
    idx = 0; wr_cnt = 0; rd_cnt = 0; rsp_cnt = 0; prev_nz = 1'b0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 4'd15; cmd_wr = wr_seq[0]; cmd_wdata = wd_seq[0];
    for (int cyc = 0; cyc < 60 && !(idx == 4 && rsp_cnt == 2); cyc++) begin
      logic accept;
      accept = cmd_valid & cmd_ready;
      if (ram_wr_rd != 2'b00) begin
        n_cmp++; if (prev_nz !== 1'b0) begin n_err++; $display("FAIL b2b_gap: got back-to-back strobe %b at cycle %0d", ram_wr_rd, cyc); end
        n_cmp++; if (ram_addr !== 4'd15) begin n_err++; $display("FAIL b2b_addr: got %0d want 15", ram_addr); end
      end
      n_cmp++; if (ram_wr_rd === 2'b11) begin n_err++; $display("FAIL b2b_illegal: got 11 want not 11"); end
      if (ram_wr_rd == 2'b10) wr_cnt++;
      if (ram_wr_rd == 2'b01) rd_cnt++;
      if (rsp_valid && rsp_ready) begin
        if (rsp_cnt < 2) begin
          n_cmp++; if (rsp_data !== exp_rsp[rsp_cnt]) begin n_err++; $display("FAIL b2b_rsp[%0d]: got %0h want %0h", rsp_cnt, rsp_data, exp_rsp[rsp_cnt]); end
        end
        rsp_cnt++;
      end
      prev_nz = (ram_wr_rd != 2'b00);
      step();
      if (accept) begin
        idx++;
        if (idx < 4) begin
          cmd_wr = wr_seq[idx]; cmd_wdata = wd_seq[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    n_cmp++; if (idx !== 4) begin n_err++; $display("FAIL b2b_accepts: got %0d want 4", idx); end
    n_cmp++; if (wr_cnt !== 2) begin n_err++; $display("FAIL b2b_wr_strobes: got %0d want 2", wr_cnt); end
    n_cmp++; if (rd_cnt !== 2) begin n_err++; $display("FAIL b2b_rd_strobes: got %0d want 2", rd_cnt); end
    n_cmp++; if (rsp_cnt !== 2) begin n_err++; $display("FAIL b2b_rsps: got %0d want 2", rsp_cnt); end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_lat3();
    c3_valid = 1'b1; c3_wr = 1'b1; c3_addr = 4'd2; c3_wdata = 16'h00AB;
    step();
    c3_valid = 1'b0;
    n_cmp++; if (c3_wr_rd !== 2'b10) begin n_err++; $display("FAIL l3_wr_strobe: got %b want 10", c3_wr_rd); end
    step();
    c3_rsp_ready = 1'b1;
    c3_valid = 1'b1; c3_wr = 1'b0; c3_addr = 4'd2;
    step();
    c3_valid = 1'b0;
    n_cmp++; if (c3_wr_rd !== 2'b01) begin n_err++; $display("FAIL l3_rd_strobe: got %b want 01", c3_wr_rd); end
    for (int k = 2; k <= 4; k++) begin
      step();
      n_cmp++; if (c3_rsp_valid !== 1'b0) begin n_err++; $display("FAIL l3_early[A+%0d]: got %b want 0", k, c3_rsp_valid); end
      n_cmp++; if (c3_busy !== 1'b1) begin n_err++; $display("FAIL l3_busy[A+%0d]: got %b want 1", k, c3_busy); end
    end
    step();
    n_cmp++; if (c3_rsp_valid !== 1'b1) begin n_err++; $display("FAIL l3_valid_a5: got %b want 1", c3_rsp_valid); end
    n_cmp++; if (c3_rsp_data !== 16'h00AB) begin n_err++; $display("FAIL l3_data: got %0h want ab", c3_rsp_data); end
    step();
    c3_rsp_ready = 1'b0;
    n_cmp++; if (c3_rsp_valid !== 1'b0) begin n_err++; $display("FAIL l3_one_cycle: got %b want 0", c3_rsp_valid); end
    n_cmp++; if (c3_ready !== 1'b1) begin n_err++; $display("FAIL l3_ready_back: got %b want 1", c3_ready); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd3;
    step();
    cmd_valid = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rm_in_wait: got busy %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ram_wr_rd !== 2'b00) begin n_err++; $display("FAIL rm_wr_rd: got %b want 00", ram_wr_rd); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rm_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_cmp++; if (ram_addr !== 4'd0) begin n_err++; $display("FAIL rm_addr: got %0d want 0", ram_addr); end
    step();
    step();
    rst_n = 1'b1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready: got %b want 1", cmd_ready); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rm_stale[%0d]: got %b want 0", i, rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_idle[%0d]: got %b want 0", i, busy); end
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_lat1();
    test_backpressure();
    test_back_to_back();
    test_lat3();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
